// File: rtl/mem_bus_ctrl_pkg.sv
// rtl/mem_bus_ctrl_pkg.sv - shared types and constants for the memory bus sequencer
package mem_bus_ctrl_pkg;

   localparam int unsigned ADDR_W = 64;
   localparam int unsigned DATA_W = 64;
   localparam int unsigned MASK_W = DATA_W / 8;
   localparam int unsigned CNT_W  = 16;

   localparam logic [MASK_W-1:0] RD_MASK = {MASK_W{1'b1}};

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_RSP  = 2'd2,
      ST_DONE = 2'd3
   } state_e;

   function automatic logic [ADDR_W-1:0] align_addr(input logic [ADDR_W-1:0] a);
      return {a[ADDR_W-1:3], 3'b000};
   endfunction

endpackage

// File: rtl/mem_bus_ctrl.sv
// rtl/mem_bus_ctrl.sv - single-outstanding memory transaction sequencer
// Issues one request per load/store, stalls until the response or timeout, then holds the result.
module mem_bus_ctrl
   import mem_bus_ctrl_pkg::*;
#(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              ex_valid,
   input  logic              ex_is_load,
   input  logic              ex_is_store,
   input  logic [ADDR_W-1:0] ex_addr,
   input  logic [DATA_W-1:0] ex_wr_data,
   input  logic [MASK_W-1:0] ex_byte_en,
   input  logic              ex_adv,
   input  logic              flush,
   output logic              mem_stall,
   output logic              mem_done,
   output logic              mem_err,
   output logic [DATA_W-1:0] mem_rd_data,
   output logic              bus_req_valid,
   input  logic              bus_req_ready,
   output logic [ADDR_W-1:0] bus_req_addr,
   output logic              bus_req_wen,
   output logic [DATA_W-1:0] bus_req_wdata,
   output logic [MASK_W-1:0] bus_req_wmask,
   input  logic              bus_rsp_valid,
   output logic              bus_rsp_ready,
   input  logic [DATA_W-1:0] bus_rsp_rdata,
   input  logic              bus_rsp_err
);

   localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              wen_q, wen_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [MASK_W-1:0] wmask_q, wmask_d;
   logic              drop_q, drop_d;
   logic              err_q, err_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [DATA_W-1:0] rd_data_q, rd_data_d;

   logic do_load, do_store, op;

   // A store with no lanes enabled is a no-op; load+store together counts as a store.
   assign do_store = ex_is_store & (|ex_byte_en);
   assign do_load  = ex_is_load & ~ex_is_store;
   assign op       = ex_valid & ~flush & (do_load | do_store);

   always_comb begin
      state_d       = state_q;
      addr_d        = addr_q;
      wen_d         = wen_q;
      wdata_d       = wdata_q;
      wmask_d       = wmask_q;
      drop_d        = drop_q;
      err_d         = err_q;
      cnt_d         = cnt_q;
      rd_data_d     = rd_data_q;
      mem_stall     = 1'b0;
      bus_req_valid = 1'b0;
      bus_rsp_ready = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            mem_stall = op;
            if (op) begin
               addr_d  = align_addr(ex_addr);
               wen_d   = ex_is_store;
               wdata_d = ex_is_store ? ex_wr_data : '0;
               wmask_d = ex_is_store ? ex_byte_en : RD_MASK;
               drop_d  = 1'b0;
               err_d   = 1'b0;
               state_d = ST_REQ;
            end
         end
         ST_REQ: begin
            mem_stall     = 1'b1;
            bus_req_valid = 1'b1;
            if (flush) drop_d = 1'b1;
            if (bus_req_ready) begin
               cnt_d   = '0;
               state_d = ST_RSP;
            end
         end
         ST_RSP: begin
            mem_stall     = 1'b1;
            bus_rsp_ready = 1'b1;
            if (flush) drop_d = 1'b1;
            if (bus_rsp_valid) begin
               if (!wen_q) rd_data_d = bus_rsp_rdata;
               err_d   = bus_rsp_err;
               state_d = ST_DONE;
            end else if (cnt_q == TO_LAST) begin
               err_d     = 1'b1;
               rd_data_d = '0;
               state_d   = ST_DONE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ST_DONE: begin
            // A squashed transaction has nobody waiting for it, so leave without ex_adv.
            if (drop_q || ex_adv || flush) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         drop_q  <= 1'b0;
         err_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         drop_q  <= drop_d;
         err_q   <= err_d;
         cnt_q   <= cnt_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr_q    <= '0;
         wen_q     <= 1'b0;
         wdata_q   <= '0;
         wmask_q   <= '0;
         rd_data_q <= '0;
      end else begin
         addr_q    <= addr_d;
         wen_q     <= wen_d;
         wdata_q   <= wdata_d;
         wmask_q   <= wmask_d;
         rd_data_q <= rd_data_d;
      end
   end

   assign bus_req_addr  = addr_q;
   assign bus_req_wen   = wen_q;
   assign bus_req_wdata = wdata_q;
   assign bus_req_wmask = wmask_q;
   assign mem_rd_data   = rd_data_q;
   assign mem_done      = (state_q == ST_DONE) & ~drop_q;
   assign mem_err       = (state_q == ST_DONE) & err_q & ~drop_q;

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// tb/tb_mem_bus_ctrl.sv - scoreboard bench for mem_bus_ctrl
module tb_mem_bus_ctrl;

   logic        clk;
   logic        rst_n;
   logic        ex_valid, ex_is_load, ex_is_store, ex_adv, flush;
   logic [63:0] ex_addr, ex_wr_data;
   logic [7:0]  ex_byte_en;
   logic        mem_stall, mem_done, mem_err;
   logic [63:0] mem_rd_data;
   logic        bus_req_valid, bus_req_ready, bus_req_wen;
   logic [63:0] bus_req_addr, bus_req_wdata;
   logic [7:0]  bus_req_wmask;
   logic        bus_rsp_valid, bus_rsp_ready, bus_rsp_err;
   logic [63:0] bus_rsp_rdata;

   logic        rsp_v_r, late_rsp;
   int          cfg_req_wait, cfg_rsp_wait;
   logic [63:0] cfg_rdata;
   logic        cfg_err;

   int total = 0;
   int bad   = 0;

   logic [136:0] exp_req[$];
   logic [64:0]  exp_rsp[$];

   assign bus_rsp_valid = rsp_v_r | late_rsp;

   mem_bus_ctrl #(.TIMEOUT(8)) dut (
      .clk(clk), .rst_n(rst_n),
      .ex_valid(ex_valid), .ex_is_load(ex_is_load), .ex_is_store(ex_is_store),
      .ex_addr(ex_addr), .ex_wr_data(ex_wr_data), .ex_byte_en(ex_byte_en),
      .ex_adv(ex_adv), .flush(flush),
      .mem_stall(mem_stall), .mem_done(mem_done), .mem_err(mem_err), .mem_rd_data(mem_rd_data),
      .bus_req_valid(bus_req_valid), .bus_req_ready(bus_req_ready), .bus_req_addr(bus_req_addr),
      .bus_req_wen(bus_req_wen), .bus_req_wdata(bus_req_wdata), .bus_req_wmask(bus_req_wmask),
      .bus_rsp_valid(bus_rsp_valid), .bus_rsp_ready(bus_rsp_ready),
      .bus_rsp_rdata(bus_rsp_rdata), .bus_rsp_err(bus_rsp_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [136:0] act, input logic [136:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Bus slave: ready after cfg_req_wait cycles, response after cfg_rsp_wait RSP cycles (-1 = never).
   initial begin
      bus_req_ready = 1'b0;
      rsp_v_r       = 1'b0;
      bus_rsp_rdata = '0;
      bus_rsp_err   = 1'b0;
      forever begin
         int req_cnt;
         int rsp_cnt;
         @(negedge clk);
         if (!rst_n) begin
            bus_req_ready = 1'b0;
            rsp_v_r       = 1'b0;
            req_cnt       = 0;
            rsp_cnt       = 0;
         end else begin
            if (bus_req_valid) begin
               if (!bus_req_ready) begin
                  if (req_cnt >= cfg_req_wait) bus_req_ready = 1'b1;
                  else req_cnt++;
               end
            end else begin
               bus_req_ready = 1'b0;
               req_cnt       = 0;
            end
            if (bus_rsp_ready) begin
               if (!rsp_v_r) begin
                  if (cfg_rsp_wait >= 0 && rsp_cnt >= cfg_rsp_wait) begin
                     rsp_v_r       = 1'b1;
                     bus_rsp_rdata = cfg_rdata;
                     bus_rsp_err   = cfg_err;
                  end else begin
                     rsp_cnt++;
                  end
               end
            end else begin
               rsp_v_r = 1'b0;
               rsp_cnt = 0;
            end
         end
      end
   end

   // Request monitor: fields must match the expected request on every cycle it is offered.
   always @(negedge clk) begin
      if (rst_n && bus_req_valid) begin
         if (exp_req.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_req: got addr %0h expected no request", bus_req_addr);
         end else begin
            chk("req_fields", {bus_req_addr, bus_req_wen, bus_req_wdata, bus_req_wmask}, exp_req[0]);
            if (bus_req_ready) void'(exp_req.pop_front());
         end
      end
   end

   // Result monitor: compares every cycle mem_done is shown, retires on ex_adv/flush.
   always @(negedge clk) begin
      if (rst_n && mem_done) begin
         if (exp_rsp.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_done: got rd %0h err %0b expected no result", mem_rd_data, mem_err);
         end else begin
            chk("result", 137'({mem_rd_data, mem_err}), 137'(exp_rsp[0]));
            if (ex_adv || flush) void'(exp_rsp.pop_front());
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic issue(input logic ld, input logic st, input logic [63:0] a,
                        input logic [63:0] wd, input logic [7:0] be);
      @(posedge clk); #1;
      ex_valid    = 1'b1;
      ex_is_load  = ld;
      ex_is_store = st;
      ex_addr     = a;
      ex_wr_data  = wd;
      ex_byte_en  = be;
   endtask

   task automatic wait_stall(output int stalls, output logic done, output logic err);
      stalls = 0;
      done   = 1'b0;
      err    = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (!mem_stall) begin
            done = mem_done;
            err  = mem_err;
            return;
         end
         stalls++;
      end
      total++;
      bad++;
      $display("FAIL stall_bound: got stall after 100 cycles expected release");
   endtask

   task automatic release_op();
      @(posedge clk); #1;
      ex_adv      = 1'b1;
      ex_valid    = 1'b0;
      ex_is_load  = 1'b0;
      ex_is_store = 1'b0;
      @(posedge clk); #1;
      ex_adv = 1'b0;
   endtask

   initial begin
      int   stalls;
      logic done, err, seen;

      rst_n = 1'b0;
      ex_valid = 0; ex_is_load = 0; ex_is_store = 0; ex_adv = 0; flush = 0;
      ex_addr = '0; ex_wr_data = '0; ex_byte_en = '0; late_rsp = 0;
      cfg_req_wait = 0; cfg_rsp_wait = 0; cfg_rdata = '0; cfg_err = 0;

      repeat (2) @(negedge clk);
      chk("reset_outputs", 137'({mem_stall, mem_done, mem_err, mem_rd_data, bus_req_valid,
          bus_req_addr, bus_req_wen, bus_req_wdata, bus_req_wmask, bus_rsp_ready}), 137'(0));
      @(posedge clk); #1;
      rst_n = 1'b1;

      // Load, zero-wait bus
      cfg_req_wait = 0; cfg_rsp_wait = 0; cfg_rdata = 64'h1122334455667788; cfg_err = 0;
      exp_req.push_back({64'h8000_0010, 1'b0, 64'h0, 8'hFF});
      exp_rsp.push_back({64'h1122334455667788, 1'b0});
      issue(1, 0, 64'h8000_0013, 64'h0, 8'h00);
      wait_stall(stalls, done, err);
      chk("load_stall_cycles", 137'(stalls), 137'(3));
      chk("load_done", 137'({done, err}), 137'(2'b10));
      release_op();

      // Halfword store at byte 6, slow ready; read word must stay unchanged
      cfg_req_wait = 4; cfg_rsp_wait = 0; cfg_rdata = 64'hDEAD_BEEF_CAFE_F00D;
      exp_req.push_back({64'h1000, 1'b1, 64'hBEEF_0000_0000_0000, 8'hC0});
      exp_rsp.push_back({64'h1122334455667788, 1'b0});
      issue(0, 1, 64'h1006, 64'hBEEF_0000_0000_0000, 8'hC0);
      wait_stall(stalls, done, err);
      chk("store_stall_cycles", 137'(stalls), 137'(7));
      chk("store_done", 137'({done, err}), 137'(2'b10));
      release_op();

      // Load and store both flagged behaves as a store
      cfg_req_wait = 0;
      exp_req.push_back({64'h20, 1'b1, 64'h0000_0000_5566_7788, 8'h0F});
      exp_rsp.push_back({64'h1122334455667788, 1'b0});
      issue(1, 1, 64'h21, 64'h0000_0000_5566_7788, 8'h0F);
      wait_stall(stalls, done, err);
      chk("ldst_done", 137'({done, err}), 137'(2'b10));
      release_op();

      // Store with no lanes is a no-op
      issue(0, 1, 64'h2000, 64'h1234, 8'h00);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("noop_store", 137'({mem_stall, bus_req_valid, mem_done}), 137'(0));
      end
      ex_valid = 0; ex_is_store = 0;

      // Timeout after 8 RSP cycles, late response ignored
      cfg_rsp_wait = -1;
      exp_req.push_back({64'h3008, 1'b0, 64'h0, 8'hFF});
      exp_rsp.push_back({64'h0, 1'b1});
      issue(1, 0, 64'h300C, 64'h0, 8'h00);
      wait_stall(stalls, done, err);
      chk("timeout_stall_cycles", 137'(stalls), 137'(10));
      chk("timeout_done", 137'({done, err}), 137'(2'b11));
      late_rsp = 1'b1;
      @(negedge clk);
      chk("late_rsp_ready", 137'({bus_rsp_ready, mem_rd_data}), 137'(0));
      release_op();
      @(negedge clk);
      chk("late_rsp_idle", 137'({bus_rsp_ready, mem_stall}), 137'(0));
      late_rsp = 1'b0;

      // Flush during RSP with error response: completes silently
      cfg_rsp_wait = 2; cfg_err = 1; cfg_rdata = 64'hFFFF_0000_FFFF_0000;
      exp_req.push_back({64'h40, 1'b0, 64'h0, 8'hFF});
      issue(1, 0, 64'h40, 64'h0, 8'h00);
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(negedge clk);
         seen = bus_rsp_ready;
      end
      chk("flush_reach_rsp", 137'(seen), 137'(1));
      @(posedge clk); #1;
      flush = 1'b1; ex_valid = 0; ex_is_load = 0;
      @(posedge clk); #1;
      flush = 1'b0;
      wait_stall(stalls, done, err);
      chk("flush_dropped", 137'({done, err}), 137'(0));
      release_op();

      // Following load proceeds normally
      cfg_rsp_wait = 1; cfg_err = 0; cfg_rdata = 64'h0123_4567_89AB_CDEF;
      exp_req.push_back({64'h48, 1'b0, 64'h0, 8'hFF});
      exp_rsp.push_back({64'h0123_4567_89AB_CDEF, 1'b0});
      issue(1, 0, 64'h4F, 64'h0, 8'h00);
      wait_stall(stalls, done, err);
      chk("post_flush_stall_cycles", 137'(stalls), 137'(4));
      chk("post_flush_done", 137'({done, err}), 137'(2'b10));
      release_op();

      // Asynchronous reset while the request is waiting
      cfg_req_wait = 10; cfg_rsp_wait = 0;
      exp_req.push_back({64'h200, 1'b0, 64'h0, 8'hFF});
      issue(1, 0, 64'h200, 64'h0, 8'h00);
      seen = 1'b0;
      for (int i = 0; i < 5 && !seen; i++) begin
         @(negedge clk);
         seen = bus_req_valid;
      end
      chk("reset_reach_req", 137'(seen), 137'(1));
      #2;
      ex_valid = 0; ex_is_load = 0;
      rst_n = 1'b0;
      #1;
      chk("async_reset_drop", 137'({bus_req_valid, mem_stall}), 137'(0));
      exp_req.delete();
      @(negedge clk);
      chk("reset_regs", 137'({mem_rd_data, bus_req_addr, bus_req_wmask}), 137'(0));
      @(posedge clk); #1;
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("post_reset_idle", 137'({bus_req_valid, mem_stall, mem_done}), 137'(0));
      end

      // DONE held without ex_adv: result stable, no new request
      cfg_req_wait = 0; cfg_rsp_wait = 0; cfg_rdata = 64'hA5A5_5A5A_0F0F_F0F0;
      exp_req.push_back({64'h100, 1'b0, 64'h0, 8'hFF});
      exp_rsp.push_back({64'hA5A5_5A5A_0F0F_F0F0, 1'b0});
      issue(1, 0, 64'h104, 64'h0, 8'h00);
      wait_stall(stalls, done, err);
      chk("hold_done", 137'({done, err}), 137'(2'b10));
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("done_hold", 137'({mem_done, bus_req_valid, mem_stall}), 137'(3'b100));
      end
      release_op();

      repeat (2) @(negedge clk);
      chk("req_queue_drained", 137'(exp_req.size()), 137'(0));
      chk("rsp_queue_drained", 137'(exp_rsp.size()), 137'(0));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
